// File: rtl/ntt_pointwise_mul_pkg.sv
// Shared constants and FSM encoding for the SSA pointwise multiplier datapath.
// Lane geometry and modulus are fixed for the 16-point NTT over Z/257.
package ntt_pointwise_mul_pkg;

    localparam int LANES  = 16;
    localparam int W      = 9;
    localparam int MOD    = 257;
    localparam int LANE_W = W;
    localparam int VEC_W  = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit offset of a lane inside a packed vector: 9*lane = 8*lane + lane.
    function automatic logic [7:0] lane_base(input logic [3:0] lane);
        lane_base = {1'b0, lane, 3'b000} + {4'b0000, lane};
    endfunction

endpackage

// File: rtl/ntt_pointwise_mul_mulmod257.sv
// Combinational multiply mod 257: operand normalisation, 17-bit product and
// Fermat reduction using 256 == -1. Shared with the twiddle/scale stages.
module mulmod257
    import ntt_pointwise_mul_pkg::*;
(
    input  logic [8:0] i_a,
    input  logic [8:0] i_b,
    output logic [8:0] o_r
);

    logic [8:0]  w_an;
    logic [8:0]  w_bn;
    logic [16:0] w_p;
    logic [9:0]  w_diff;
    logic [9:0]  w_red;

    // Normalise, multiply and fold the high byte back with negative weight.
    always_comb begin
        w_an = (i_a >= 9'd257) ? (i_a - 9'd257) : i_a;
        w_bn = (i_b >= 9'd257) ? (i_b - 9'd257) : i_b;
        w_p  = {8'b0, w_an} * {8'b0, w_bn};
        // p = h*256 + l, so p mod 257 == l - h; h is at most 256.
        w_diff = {2'b00, w_p[7:0]} - {1'b0, w_p[16:8]};
        if (w_diff[9]) begin
            w_red = w_diff + 10'd257;
        end else if (w_diff >= 10'd257) begin
            w_red = w_diff - 10'd257;
        end else begin
            w_red = w_diff;
        end
        o_r = w_red[8:0];
    end

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Sequential Hadamard product of two 16-lane NTT-domain vectors mod 257, one
// lane per cycle through a single shared multiplier; lane order is preserved.
module ntt_pointwise_mul
    import ntt_pointwise_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] a_in,
    input  logic [VEC_W-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out,
    output logic             busy
);

    state_t             r_state;
    logic [3:0]         r_lane;
    logic [VEC_W-1:0]   r_a;
    logic [VEC_W-1:0]   r_b;
    logic [VEC_W-1:0]   r_res;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [7:0]         w_base;
    logic [LANE_W-1:0]  w_a_lane;
    logic [LANE_W-1:0]  w_b_lane;
    logic [LANE_W-1:0]  w_prod;

    // Select the operand lanes addressed by the lane counter.
    always_comb begin
        w_base   = lane_base(r_lane);
        w_a_lane = r_a[w_base +: LANE_W];
        w_b_lane = r_b[w_base +: LANE_W];
    end

    mulmod257 u_mulmod (
        .i_a (w_a_lane),
        .i_b (w_b_lane),
        .o_r (w_prod)
    );

    // Control FSM with status flags registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lane      <= 4'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a_in;
                        r_b        <= b_in;
                        r_lane     <= 4'd0;
                        r_state    <= ST_MUL;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    r_res[w_base +: LANE_W] <= w_prod;
                    if (r_lane == 4'd15) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_lane      <= 4'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out       = r_res;

endmodule
